// File: rtl/ndm_reset_sequencer.sv
// Ordered reset sequencer driven by the debug module's ndmreset request.
// Holds peripherals and core in reset, releases peripherals first, and gates/replays debug requests.
module ndm_reset_sequencer #(
  parameter int unsigned NR_CORES    = 1,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned RELEASE_GAP = 4
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                ndmreset,
  input  logic [NR_CORES-1:0] debug_req_in,
  output logic                periph_rst,
  output logic                core_rst,
  output logic [NR_CORES-1:0] debug_req_out,
  output logic                seq_busy,
  output logic [7:0]          reset_count
);

  localparam int unsigned MAX_CNT = (HOLD_CYCLES > RELEASE_GAP) ? HOLD_CYCLES : RELEASE_GAP;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(RELEASE_GAP - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ASSERT     = 2'd1,
    REL_PERIPH = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NR_CORES-1:0] pending_q, pending_d;
  logic [NR_CORES-1:0] dbg_d;
  logic [7:0]          count_d;

  // Next-state, hold/gap counter and debug-request gating.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    count_d   = reset_count;
    pending_d = pending_q;
    dbg_d     = '0;

    unique case (state_q)
      IDLE: begin
        if (ndmreset) begin
          state_d = ASSERT;
          cnt_d   = HOLD_LD;
        end
      end
      ASSERT: begin
        if (ndmreset) begin
          cnt_d = HOLD_LD;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = REL_PERIPH;
          cnt_d   = GAP_LD;
        end
      end
      REL_PERIPH: begin
        if (ndmreset) begin
          state_d = ASSERT;
          cnt_d   = HOLD_LD;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
          if (reset_count != 8'hFF) count_d = reset_count + 8'd1;
        end
      end
      default: begin
        state_d = ASSERT;
        cnt_d   = HOLD_LD;
      end
    endcase

    // Requests seen during reset are remembered and replayed once back in IDLE.
    if (state_q == IDLE) begin
      pending_d = '0;
      if (state_d == IDLE) dbg_d = debug_req_in | pending_q;
    end else begin
      pending_d = pending_q | debug_req_in;
    end
  end

  // State and registered outputs; outputs track the state being entered.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q       <= ASSERT;
      cnt_q         <= HOLD_LD;
      pending_q     <= '0;
      periph_rst    <= 1'b1;
      core_rst      <= 1'b1;
      seq_busy      <= 1'b1;
      debug_req_out <= '0;
      reset_count   <= 8'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pending_q     <= pending_d;
      periph_rst    <= (state_d == ASSERT);
      core_rst      <= (state_d != IDLE);
      seq_busy      <= (state_d != IDLE);
      debug_req_out <= dbg_d;
      reset_count   <= count_d;
    end
  end

endmodule
